// File: rtl/synth_pkg.sv
// synth_pkg: shared types and pitch table for the polyphonic voice engine.
//   wave_t  - wave shape select encoding (matches wave_sel)
//   KEY_DIV - base clocks-per-phase-step for the 13 keys of one octave
//   key_div - divider for any key index 0..31; keys above the base table
//             reuse the entry one octave (12 keys) lower at half the divider
package synth_pkg;

  typedef enum logic [1:0] {
    SAW     = 2'd0,
    SQUARE  = 2'd1,
    TRI     = 2'd2,
    INV_SAW = 2'd3
  } wave_t;

  localparam int          NUM_BASE_KEYS = 13;
  localparam logic [15:0] KEY_DIV [NUM_BASE_KEYS] = '{
    16'd75, 16'd70, 16'd67, 16'd63, 16'd59, 16'd56, 16'd53,
    16'd50, 16'd47, 16'd44, 16'd42, 16'd40, 16'd37
  };

  // Iterative form of "key_div(idx-12) >> 1": at most two octave folds are
  // needed to bring any 5-bit index under 13 (31 -> 19 -> 7).
  function automatic logic [15:0] key_div(input logic [4:0] idx);
    logic [4:0]  i;
    logic [1:0]  sh;
    logic [15:0] d;
    i  = idx;
    sh = 2'd0;
    for (int n = 0; n < 2; n++) begin
      if (i >= 5'd13) begin
        i  = i - 5'd12;
        sh = sh + 2'd1;
      end
    end
    d = KEY_DIV[i[3:0]] >> sh;
    if (d == 16'd0) d = 16'd1;
    return d;
  endfunction

endpackage

// File: rtl/voice_osc.sv
// voice_osc: one voice's phase accumulator and wave shaper.
//   clk, nrst  - clock, synchronous active-low reset
//   busy       - voice currently assigned; free voices hold zero and output 0
//   clr        - restart the note (allocation, steal or release this cycle)
//   key_idx    - key driving this voice, selects the pitch divider
//   oct_sel    - octave-down amount, multiplies the period by 2^oct_sel
//   wave_sel   - wave shape (wave_t encoding)
//   sample     - shaped sample of this voice (combinational from phase)
module voice_osc
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int KEY_W    = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                busy,
  input  logic                clr,
  input  logic [KEY_W-1:0]    key_idx,
  input  logic [1:0]          oct_sel,
  input  logic [1:0]          wave_sel,
  output logic [SAMPLE_W-1:0] sample
);

  logic [15:0]         div_cnt;
  logic [SAMPLE_W-1:0] phase;
  logic [15:0]         limit;
  logic [SAMPLE_W-1:0] phase_x2;

  assign limit    = (key_div(5'(key_idx)) << oct_sel) - 16'd1;
  assign phase_x2 = phase << 1;

  // A count already past the limit (octave raised mid-note) restarts the
  // period without stepping the phase; only an exact hit steps it.
  always_ff @(posedge clk) begin
    if (!nrst || clr || !busy) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (div_cnt == limit) begin
      div_cnt <= '0;
      phase   <= phase + 1'b1;
    end else if (div_cnt > limit) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_comb begin
    sample = '0;
    if (busy) begin
      case (wave_t'(wave_sel))
        SAW:     sample = phase;
        SQUARE:  sample = phase[SAMPLE_W-1] ? '1 : '0;
        TRI:     sample = phase[SAMPLE_W-1] ? ~phase_x2 : phase_x2;
        INV_SAW: sample = ~phase;
        default: sample = '0;
      endcase
    end
  end

endmodule

// File: rtl/poly_voice_engine.sv
// poly_voice_engine: pool of NUM_VOICES voices shared between NUM_KEYS keys.
//   clk, nrst     - clock, synchronous active-low reset
//   key_i         - held-key levels, 1 = held
//   oct_sel       - octave-down amount 0..3
//   wave_sel      - 0 saw, 1 square, 2 triangle, 3 inverted saw
//   sample_o      - registered average of all voice samples
//   voice_busy_o  - per-voice assigned flag
//   steal_o       - one-cycle pulse when a held voice is taken for a new key
// Release and allocation are both decided on the current state, so a voice
// released this cycle only becomes allocatable on the next one.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8,
  parameter int AGE_W      = 12
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NUM_KEYS-1:0]   key_i,
  input  logic [1:0]            oct_sel,
  input  logic [1:0]            wave_sel,
  output logic [SAMPLE_W-1:0]   sample_o,
  output logic [NUM_VOICES-1:0] voice_busy_o,
  output logic                  steal_o
);

  localparam int KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_SHIFT = $clog2(NUM_VOICES);
  localparam int MIX_W     = SAMPLE_W + MIX_SHIFT;

  logic [NUM_KEYS-1:0]   key_q;
  logic [NUM_VOICES-1:0] busy;
  logic [KEY_W-1:0]      v_key    [NUM_VOICES];
  logic [AGE_W-1:0]      age      [NUM_VOICES];
  logic [SAMPLE_W-1:0]   v_sample [NUM_VOICES];

  logic [NUM_KEYS-1:0]   press, assigned, pending, steal_cand;
  logic [NUM_VOICES-1:0] rel, voice_clr;
  logic                  free_any, do_alloc, do_steal;
  logic [VIDX_W-1:0]     free_idx, old_idx;
  logic [KEY_W-1:0]      pend_idx, steal_idx;
  logic [AGE_W-1:0]      best_age;
  logic [MIX_W-1:0]      mix_sum;

  always_comb begin
    assigned  = '0;
    rel       = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    pend_idx  = '0;
    steal_idx = '0;
    old_idx   = '0;
    best_age  = age[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (busy[v]) begin
        assigned[v_key[v]] = 1'b1;
        rel[v]             = ~key_i[v_key[v]];
      end
    end
    press      = key_i & ~key_q;
    pending    = key_i & ~assigned;
    steal_cand = press & pending;
    // Descending scans leave the lowest matching index as the winner.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!busy[v]) begin
        free_any = 1'b1;
        free_idx = VIDX_W'(v);
      end
    end
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending[k])    pend_idx  = KEY_W'(k);
      if (steal_cand[k]) steal_idx = KEY_W'(k);
    end
    // Strict compare keeps the lowest index on equal ages.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > best_age) begin
        best_age = age[v];
        old_idx  = VIDX_W'(v);
      end
    end
    do_alloc = free_any && (|pending);
    do_steal = !free_any && (|steal_cand);
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_clr[v] = rel[v] || (do_alloc && (free_idx == VIDX_W'(v)))
                            || (do_steal && (old_idx == VIDX_W'(v)));
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      key_q   <= '0;
      busy    <= '0;
      steal_o <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        v_key[v] <= '0;
        age[v]   <= '0;
      end
    end else begin
      key_q   <= key_i;
      steal_o <= do_steal;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (busy[v]) begin
          if (rel[v]) busy[v] <= 1'b0;
          if (age[v] != '1) age[v] <= age[v] + 1'b1;
        end
      end
      if (do_alloc) begin
        busy[free_idx]  <= 1'b1;
        v_key[free_idx] <= pend_idx;
        age[free_idx]   <= '0;
      end
      if (do_steal) begin
        busy[old_idx]  <= 1'b1;
        v_key[old_idx] <= steal_idx;
        age[old_idx]   <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_osc #(
      .SAMPLE_W (SAMPLE_W),
      .KEY_W    (KEY_W)
    ) u_osc (
      .clk      (clk),
      .nrst     (nrst),
      .busy     (busy[g]),
      .clr      (voice_clr[g]),
      .key_idx  (v_key[g]),
      .oct_sel  (oct_sel),
      .wave_sel (wave_sel),
      .sample   (v_sample[g])
    );
  end

  // Sum width has log2(NUM_VOICES) guard bits, so the average is exact.
  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_sum = mix_sum + MIX_W'(v_sample[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) sample_o <= '0;
    else       sample_o <= SAMPLE_W'(mix_sum >> MIX_SHIFT);
  end

  assign voice_busy_o = busy;

endmodule

// File: tb/tb_poly_voice_engine.sv
// Testbench for poly_voice_engine with default parameters.
module tb_poly_voice_engine;

  localparam int K_BUSY   = 0;
  localparam int K_STEAL  = 1;
  localparam int K_SAMPLE = 2;
  localparam int K_KEY    = 3;
  localparam int K_PHASE  = 4;
  localparam int K_DIV    = 5;

  typedef struct {
    int          kind;
    int          vidx;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [12:0] key_i;
  logic [1:0]  oct_sel;
  logic [1:0]  wave_sel;
  logic [7:0]  sample_o;
  logic [3:0]  voice_busy_o;
  logic        steal_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  poly_voice_engine dut (
    .clk          (clk),
    .nrst         (nrst),
    .key_i        (key_i),
    .oct_sel      (oct_sel),
    .wave_sel     (wave_sel),
    .sample_o     (sample_o),
    .voice_busy_o (voice_busy_o),
    .steal_o      (steal_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // watchdog: the stimulus must finish within a bounded time
  initial begin
    #2000000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // monitor: expectations pushed after an edge are compared at the next negedge
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [15:0] act;
        e = exp_q.pop_front();
        case (e.kind)
          K_BUSY:   act = 16'(voice_busy_o);
          K_STEAL:  act = 16'(steal_o);
          K_SAMPLE: act = 16'(sample_o);
          K_KEY:    act = 16'(dut.v_key[e.vidx]);
          K_PHASE:  act = 16'(dut.g_voice[0].u_osc.phase);
          default:  act = dut.g_voice[0].u_osc.div_cnt;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
        end
      end
    end
  end

  // driver tasks
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input int vidx, input int val, input string name);
    exp_t e;
    e.kind = kind;
    e.vidx = vidx;
    e.val  = 16'(val);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_out(input string name, input int busy, input int steal, input int sample);
    push(K_BUSY,   0, busy,   {name, ".busy"});
    push(K_STEAL,  0, steal,  {name, ".steal"});
    push(K_SAMPLE, 0, sample, {name, ".sample"});
  endtask

  task automatic exp_bs(input string name, input int busy, input int steal);
    push(K_BUSY,  0, busy,  {name, ".busy"});
    push(K_STEAL, 0, steal, {name, ".steal"});
  endtask

  initial begin
    nrst = 1'b0; key_i = '0; oct_sel = 2'd0; wave_sel = 2'd0;

    // reset, all keys low
    adv(1); exp_out("rst0", 0, 0, 0);
    adv(1); exp_out("rst1", 0, 0, 0);
    check_val("rst_busy_now",   16'(voice_busy_o), 16'd0);
    check_val("rst_steal_now",  16'(steal_o),      16'd0);
    check_val("rst_sample_now", 16'(sample_o),     16'd0);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv(1); exp_out("idle", 0, 0, 0);
    end

    // key 0, saw, oct 0: period 75, sample_o = phase/4
    key_i = 13'h0001;
    adv(1);   exp_out("k0_alloc", 1, 0, 0); push(K_KEY, 0, 0, "k0_key");
    adv(74);  push(K_PHASE, 0, 0, "k0_ph74"); push(K_DIV, 0, 74, "k0_div74");
    adv(1);   push(K_PHASE, 0, 1, "k0_ph75"); push(K_DIV, 0, 0, "k0_div75");
    adv(225); push(K_PHASE, 0, 4, "k0_ph300"); push(K_SAMPLE, 0, 0, "k0_s300");
    adv(1);   push(K_SAMPLE, 0, 1, "k0_s301");
    key_i = '0;
    adv(1);   exp_out("k0_rel", 0, 0, 1); push(K_PHASE, 0, 0, "k0_relph");
    adv(1);   exp_out("k0_rel2", 0, 0, 0);

    // keys 2,5,7 together: one allocation per cycle, lowest key first
    key_i = 13'h00A4;
    adv(1); exp_bs("c1", 4'b0001, 0); push(K_KEY, 0, 2, "c1_v0");
    adv(1); exp_bs("c2", 4'b0011, 0); push(K_KEY, 1, 5, "c2_v1");
    adv(1); exp_bs("c3", 4'b0111, 0); push(K_KEY, 2, 7, "c3_v2");
    adv(1); exp_bs("c4", 4'b0111, 0);
    key_i = '0;
    adv(1); exp_bs("c_rel", 0, 0);
    adv(1); exp_out("c_rel2", 0, 0, 0);

    // keys 0-3 fill the pool, key 9 steals the oldest voice (voice 0)
    key_i = 13'h000F;
    adv(1); exp_bs("s1", 4'b0001, 0);
    adv(1); exp_bs("s2", 4'b0011, 0);
    adv(1); exp_bs("s3", 4'b0111, 0);
    adv(1); exp_bs("s4", 4'b1111, 0); push(K_KEY, 3, 3, "s4_v3");
    key_i = 13'h020F;
    adv(1); exp_bs("steal", 4'b1111, 1); push(K_KEY, 0, 9, "steal_v0");
    adv(1); exp_bs("steal_end", 4'b1111, 0); push(K_KEY, 0, 9, "steal_v0b");
    key_i = 13'h000F;
    adv(1); exp_bs("k9_rel", 4'b1110, 0);
    adv(1); exp_bs("k0_back", 4'b1111, 0); push(K_KEY, 0, 0, "k0_back_v0");
    key_i = '0;
    adv(1); exp_bs("s_rel", 0, 0);
    adv(1); exp_out("s_rel2", 0, 0, 0);

    // key 12, oct 2: period 148; oct change mid-count with div 100
    key_i = 13'h1000; oct_sel = 2'd2;
    adv(1);   exp_bs("o_alloc", 1, 0); push(K_KEY, 0, 12, "o_key");
    adv(147); push(K_PHASE, 0, 0, "o_ph147"); push(K_DIV, 0, 147, "o_div147");
    adv(1);   push(K_PHASE, 0, 1, "o_ph148"); push(K_DIV, 0, 0, "o_div148");
    adv(100); push(K_DIV, 0, 100, "o_div100");
    oct_sel = 2'd0;
    adv(1);   push(K_DIV, 0, 0, "o_divrst"); push(K_PHASE, 0, 1, "o_phhold");
    adv(36);  push(K_DIV, 0, 36, "o_div36"); push(K_PHASE, 0, 1, "o_ph_pre");
    adv(1);   push(K_DIV, 0, 0, "o_div37"); push(K_PHASE, 0, 2, "o_ph37");
    key_i = '0;
    adv(1);   exp_bs("o_rel", 0, 0);
    adv(1);   exp_out("o_rel2", 0, 0, 0);

    // wave shapes at phase 192 (key 12, oct 0, 37 clocks per step)
    key_i = 13'h1000;
    adv(1);    exp_bs("w_alloc", 1, 0);
    adv(7103); push(K_PHASE, 0, 191, "w_ph191");
    adv(1);    push(K_PHASE, 0, 192, "w_ph192");
    adv(1);    push(K_SAMPLE, 0, 48, "w_saw");
    wave_sel = 2'd1;
    adv(1);    push(K_SAMPLE, 0, 63, "w_square");
    wave_sel = 2'd2;
    adv(1);    push(K_SAMPLE, 0, 31, "w_tri");
    wave_sel = 2'd3;
    adv(1);    push(K_SAMPLE, 0, 15, "w_inv");
    key_i = '0;
    adv(1);    exp_bs("w_rel", 0, 0);
    adv(1);    exp_out("w_rel2", 0, 0, 0);

    // reset mid-note with key 0 held, inverted saw
    key_i = 13'h0001;
    adv(1); exp_out("r_alloc", 1, 0, 0);
    adv(1); exp_out("r_play", 1, 0, 63);
    nrst = 1'b0;
    adv(1); exp_out("r_reset", 0, 0, 0); push(K_PHASE, 0, 0, "r_phase");
    nrst = 1'b1;
    adv(1); exp_out("r_realloc", 1, 0, 0); push(K_KEY, 0, 0, "r_key");
    adv(1); exp_out("r_play2", 1, 0, 63);
    key_i = '0;
    adv(2);

    // final report
    #6;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
